// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared opcode constants and sequencer state encoding for the
//            MUL/DIV control sequencer.
// Contents : OP_MUL, OP_DIV  - the two ALU op codes the sequencer accepts
//            state_t         - sequencer states, 3-bit encoding
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [4:0] OP_MUL = 5'b01010;
    localparam logic [4:0] OP_DIV = 5'b01011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T_Y  = 3'd1,
        T_OP = 3'd2,
        T_LO = 3'd3,
        T_HI = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : reg_onehot_dec
// Purpose  : Register index to one-hot bus-out enable decoder.
// Ports    : idx    in  RSELW  register index
//            en     in  1      decoder enable; all outputs 0 when low
//            onehot out NREGS  one-hot enable vector (never multi-hot)
// Revision : 1.0 - initial release
// ============================================================================
module reg_onehot_dec #(
    parameter int NREGS = 16,
    parameter int RSELW = 4
) (
    input  logic [RSELW-1:0] idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // Indices beyond NREGS-1 select nothing rather than aliasing a register.
    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        assign onehot[i] = en && (idx == RSELW'(i));
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_control_seq
// Purpose  : Multicycle control sequencer for MUL/DIV on data_path.
//            Sequence: rA->Y, rB + ALU op -> Z(64), Zlow->LO, Zhigh->HI.
// Ports    : Clock     in   system clock (rising edge)
//            clear     in   asynchronous reset, active-low
//            start     in   request, sampled only in IDLE
//            opcode    in   OP_MUL / OP_DIV, captured with start
//            ra, rb    in   source register indices, captured with start
//            bus_data  in   data_path BusOut (zero trap only)
//            busy      out  state != IDLE
//            done      out  one-cycle pulse at sequence end
//            err_op    out  one-cycle pulse after start with illegal opcode
//            div_zero  out  one-cycle pulse with done on trapped divide
//            op        out  ALU op, held from T_OP to DONE, else 0
//            Rout      out  one-hot register bus-out enables
//            Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin
//                      out  data_path strobes
// Config   : MULDIV_ZERO_TRAP_EN - divide by zero (bus_data==0 in T_OP)
//            jumps T_OP->DONE and raises div_zero with done.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_control_seq
    import muldiv_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5,
    parameter int RSELW = 4
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [RSELW-1:0] ra,
    input  logic [RSELW-1:0] rb,
    input  logic [31:0]      bus_data,
    output logic             busy,
    output logic             done,
    output logic             err_op,
    output logic             div_zero,
    output logic [OPW-1:0]   op,
    output logic [NREGS-1:0] Rout,
    output logic             Yin,
    output logic             ZHighin,
    output logic             Zlowin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIin,
    output logic             LOin
);

    state_t           state_q, state_d;
    logic [RSELW-1:0] ra_q, rb_q;
    logic [OPW-1:0]   opc_q;
    logic             load;
    logic             err_d;
    logic             dz_d;
    logic             legal;
    logic [RSELW-1:0] dec_idx;
    logic             dec_en;

    assign legal = (opcode == OPW'(OP_MUL)) || (opcode == OPW'(OP_DIV));

`ifndef MULDIV_ZERO_TRAP_EN
    logic unused_bus;
    assign unused_bus = ^bus_data;
`endif

    // Next-state logic and the pulse flags that are registered alongside it.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        err_d   = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = T_Y;
                        load    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            T_Y:  state_d = T_OP;
            T_OP: begin
`ifdef MULDIV_ZERO_TRAP_EN
                // Rout[rb] is driving the bus now, so bus_data is the divisor.
                if ((opc_q == OPW'(OP_DIV)) && (bus_data == 32'd0)) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                end else begin
                    state_d = T_LO;
                end
`else
                state_d = T_LO;
`endif
            end
            T_LO:    state_d = T_HI;
            T_HI:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured fields and every strobe are registered; strobes are
    // computed from the next state so they are valid in the state's own cycle.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            opc_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_op   <= 1'b0;
            div_zero <= 1'b0;
            op       <= '0;
            Yin      <= 1'b0;
            ZHighin  <= 1'b0;
            Zlowin   <= 1'b0;
            Zhighout <= 1'b0;
            Zlowout  <= 1'b0;
            HIin     <= 1'b0;
            LOin     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ra_q  <= ra;
                rb_q  <= rb;
                opc_q <= opcode;
            end
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            err_op   <= err_d;
            div_zero <= dz_d;
            op       <= (state_d == T_OP || state_d == T_LO ||
                         state_d == T_HI || state_d == DONE) ? opc_q : '0;
            Yin      <= (state_d == T_Y);
            ZHighin  <= (state_d == T_OP);
            Zlowin   <= (state_d == T_OP);
            Zlowout  <= (state_d == T_LO);
            LOin     <= (state_d == T_LO);
            Zhighout <= (state_d == T_HI);
            HIin     <= (state_d == T_HI);
        end
    end

    // Decoder inputs are all flops, so Rout has no path from module inputs.
    assign dec_idx = (state_q == T_Y) ? ra_q : rb_q;
    assign dec_en  = (state_q == T_Y) || (state_q == T_OP);

    reg_onehot_dec #(
        .NREGS (NREGS),
        .RSELW (RSELW)
    ) u_dec (
        .idx    (dec_idx),
        .en     (dec_en),
        .onehot (Rout)
    );

endmodule
`default_nettype wire

// File: tb/tb_muldiv_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_control_seq
// Purpose  : Self-checking bench: sequencer driving a small data_path model,
//            directed cases plus random traffic against a schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_control_seq;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  opcode = '0;
    logic [3:0]  ra = '0, rb = '0;
    logic [31:0] bus;
    logic        busy, done, err_op, div_zero;
    logic [4:0]  op;
    logic [15:0] Rout;
    logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_control_seq #(.NREGS(16), .OPW(5), .RSELW(4)) dut (
        .Clock(clk), .clear(clear), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .bus_data(bus),
        .busy(busy), .done(done), .err_op(err_op), .div_zero(div_zero),
        .op(op), .Rout(Rout), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin)
    );

    // ---------------- data_path model ----------------
    logic [31:0] R [16];
    logic [31:0] Y = '0, HI = '0, LO = '0;
    logic [63:0] Z = '0;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | R[i];
        if (Zlowout)  bus = bus | Z[31:0];
        if (Zhighout) bus = bus | Z[63:32];
    end

    always @(posedge clk) begin
        if (Yin) Y <= bus;
        if (ZHighin && Zlowin) begin
            if (op == 5'b01010)      Z <= 64'(Y) * 64'(bus);
            else if (bus == 32'd0)   Z <= {Y, 32'hFFFF_FFFF};
            else                     Z <= {Y % bus, Y / bus};
        end
        if (LOin) LO <= bus;
        if (HIin) HI <= bus;
    end

    // ---------------- schedule model ----------------
    typedef struct packed {
        logic        busy, done, err, dz;
        logic [4:0]  op;
        logic [15:0] rout;
        logic        yin, zhin, zlin, zhout, zlout, hiin, loin;
        logic        res, keep;
        logic [31:0] hi, lo;
    } exp_t;

    exp_t cur = '0;
    exp_t eq[$];
    logic [31:0] com_hi = '0, com_lo = '0;

    always @(posedge clk) begin
        if (!clear) begin
            eq.delete();
            cur = '0;
        end else if (!cur.busy && start) begin
            if (opcode == 5'b01010 || opcode == 5'b01011) begin
                exp_t s1, s2, s3, s4, s5;
                logic [31:0] a, b;
                logic [63:0] p;
                logic trap;
                a = R[ra]; b = R[rb];
                s1 = '0; s1.busy = 1'b1;
                s2 = s1; s3 = s1; s4 = s1; s5 = s1;
                s1.rout = 16'd1 << ra; s1.yin = 1'b1;
                s2.rout = 16'd1 << rb; s2.op = opcode; s2.zhin = 1'b1; s2.zlin = 1'b1;
`ifdef MULDIV_ZERO_TRAP_EN
                trap = (opcode == 5'b01011) && (b == 32'd0);
`else
                trap = 1'b0;
`endif
                if (trap) begin
                    s3.op = opcode; s3.done = 1'b1; s3.dz = 1'b1;
                    s3.res = 1'b1; s3.keep = 1'b1;
                    eq.push_back(s2); eq.push_back(s3);
                end else begin
                    if (opcode == 5'b01010) p = 64'(a) * 64'(b);
                    else if (b == 32'd0)   p = {a, 32'hFFFF_FFFF};
                    else                   p = {a % b, a / b};
                    s3.op = opcode; s3.zlout = 1'b1; s3.loin = 1'b1;
                    s4.op = opcode; s4.zhout = 1'b1; s4.hiin = 1'b1;
                    s5.op = opcode; s5.done = 1'b1; s5.res = 1'b1;
                    s5.hi = p[63:32]; s5.lo = p[31:0];
                    eq.push_back(s2); eq.push_back(s3); eq.push_back(s4); eq.push_back(s5);
                end
                cur = s1;
            end else begin
                cur = '0;
                cur.err = 1'b1;
            end
        end else if (eq.size() > 0) begin
            cur = eq.pop_front();
        end else begin
            cur = '0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act, expv;
        logic [31:0] xh, xl;
        e = clear ? cur : '0;
        act  = {busy, done, err_op, div_zero, op, Rout,
                Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin};
        expv = {e.busy, e.done, e.err, e.dz, e.op, e.rout,
                e.yin, e.zhin, e.zlin, e.zhout, e.zlout, e.hiin, e.loin};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL outputs t=%0t got %h expected %h", $time, act, expv);
        end
        checks++;
        if ($countones(Rout) + int'(Zlowout) + int'(Zhighout) > 1) begin
            errors++;
            $display("FAIL bus_drivers t=%0t Rout=%h Zlowout=%b Zhighout=%b expected at most one",
                     $time, Rout, Zlowout, Zhighout);
        end
        if (e.res) begin
            xh = e.keep ? com_hi : e.hi;
            xl = e.keep ? com_lo : e.lo;
            checks++;
            if (HI !== xh || LO !== xl) begin
                errors++;
                $display("FAIL result t=%0t HI=%h LO=%h expected HI=%h LO=%h", $time, HI, LO, xh, xl);
            end
            com_hi = xh; com_lo = xl;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    // Waits for done, returns cycle number after the accept edge (0 = timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic do_op(input logic [4:0] opc, input logic [3:0] a, input logic [3:0] b,
                         output int lat);
        @(posedge clk); #1; start = 1'b1; opcode = opc; ra = a; rb = b;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat);
        if (lat != 0) lat = lat + 0;
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 16; i++) R[i] = 32'd0;
        R[3] = 32'd12; R[2] = 32'd5; R[5] = 32'd3;

        // Reset
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, err_op, div_zero, op, Rout, Yin, ZHighin, Zlowin,
                           Zhighout, Zlowout, HIin, LOin}, 32'd0);
        @(posedge clk); #1; clear = 1'b1;

        // 1: MUL 12*5
        do_op(5'b01010, 4'd3, 4'd2, lat);
        chk("mul_latency", lat, 32'd5);
        chk("mul_lo", LO, 32'd60);
        chk("mul_hi", HI, 32'd0);

        // 2: DIV 12/5
        do_op(5'b01011, 4'd3, 4'd2, lat);
        chk("div_latency", lat, 32'd5);
        chk("div_lo", LO, 32'd2);
        chk("div_hi", HI, 32'd2);

        // 3: illegal opcode
        @(posedge clk); #1; start = 1'b1; opcode = 5'b00011; ra = 4'd3; rb = 4'd2;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("illegal_err", {31'd0, err_op}, 32'd1);
        chk("illegal_busy", {31'd0, busy}, 32'd0);

        // 4: start held while busy is ignored; start in cycle 6 accepted
        @(posedge clk); #1; start = 1'b1; opcode = 5'b01010; ra = 4'd3; rb = 4'd2;
        @(posedge clk); #1; ra = 4'd5;
        wait_done(lat);
        chk("held_latency", lat, 32'd5);
        chk("held_lo", LO, 32'd60);
        @(posedge clk); #1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("b2b_rout", {16'd0, Rout}, 32'h0000_0020);
        wait_done(lat);
        chk("b2b_latency", lat, 32'd4);
        chk("b2b_lo", LO, 32'd15);

        // 5: clear during T_OP
        @(posedge clk); #1; R[3] = 32'd7;
        @(posedge clk); #1; start = 1'b1; opcode = 5'b01010; ra = 4'd3; rb = 4'd2;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; clear = 1'b0;
        #1;
        chk("abort_strobes", {Rout, 13'd0, ZHighin, Zlowin, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; clear = 1'b1;
        @(negedge clk);
        chk("abort_lo", LO, 32'd15);
        chk("abort_done", {31'd0, done}, 32'd0);

        // 6: divide by zero
        @(posedge clk); #1; R[2] = 32'd0;
        do_op(5'b01011, 4'd3, 4'd2, lat);
`ifdef MULDIV_ZERO_TRAP_EN
        chk("trap_latency", lat, 32'd3);
        chk("trap_dz", {31'd0, div_zero}, 32'd1);
        chk("trap_lo", LO, 32'd15);
`else
        chk("dz_latency", lat, 32'd5);
        chk("dz_flag", {31'd0, div_zero}, 32'd0);
        chk("dz_lo", LO, 32'hFFFF_FFFF);
        chk("dz_hi", HI, 32'd7);
`endif

        // Random traffic
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++) R[i] = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
        R[0] = 32'd0;
        for (int c = 0; c < 600; c++) begin
            int sel;
            @(posedge clk); #1;
            sel    = $urandom_range(0, 7);
            start  = ($urandom_range(0, 2) == 0);
            opcode = (sel < 3) ? 5'b01010 : (sel < 6) ? 5'b01011 : 5'($urandom_range(0, 31));
            ra     = 4'($urandom_range(0, 15));
            rb     = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
